// File: rtl/dp_score_norm_select.sv
// Normalises DP matcher scores by path length (serial restoring divide) and picks the
// minimum-score template id once every NTEMPL results.
module dp_score_norm_select #(
  parameter int unsigned BIT    = 32,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned NTEMPL = 4,
  parameter int unsigned TIDW   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dv_in,
  input  logic [BIT+12:0]          scr_in,
  input  logic [6:0]               len_in,
  input  logic [TIDW-1:0]          tid_in,
  output logic                     busy,
  output logic                     dv_o,
  output logic [BIT+13+FRAC-1:0]   nscr_o,
  output logic [TIDW-1:0]          tid_o,
  output logic                     best_dv,
  output logic [TIDW-1:0]          best_id,
  output logic [BIT+13+FRAC-1:0]   best_scr,
  output logic                     err_o
);

  localparam int unsigned SW  = BIT + 13;
  localparam int unsigned NW  = SW + FRAC;
  localparam int unsigned CW  = $clog2(NW + 1);
  localparam int unsigned RCW = $clog2(NTEMPL + 1);

  typedef enum logic [1:0] {StIdle, StDiv, StOut} state_e;

  state_e          st_q, st_d;
  logic [NW-1:0]   num_q, num_d;
  logic [7:0]      rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [6:0]      len_q, len_d;
  logic [TIDW-1:0] tid_q, tid_d;
  logic [NW-1:0]   nscr_q, nscr_d;
  logic [TIDW-1:0] tido_q, tido_d;

  logic [NW-1:0]   best_q, best_scr_q;
  logic [TIDW-1:0] best_id_q, best_ido_q;
  logic [RCW-1:0]  rcnt_q;
  logic            best_dv_q, err_q;

  logic [7:0]      rem_sh, rem_nx;
  logic            ge;
  logic [NW-1:0]   q_nx;
  logic            invalid;

  // Remainder stays below len (<=127), so the shifted value always fits in 8 bits.
  always_comb begin
    rem_sh  = {rem_q[6:0], num_q[NW-1]};
    ge      = rem_q[7] | (rem_sh >= {1'b0, len_q});
    rem_nx  = ge ? (rem_sh - {1'b0, len_q}) : rem_sh;
    q_nx    = {num_q[NW-2:0], ge};
    invalid = (scr_in == {SW{1'b1}}) || (len_in == 7'd0);
  end

  always_comb begin
    st_d   = st_q;
    num_d  = num_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    len_d  = len_q;
    tid_d  = tid_q;
    nscr_d = nscr_q;
    tido_d = tido_q;
    unique case (st_q)
      StIdle: begin
        if (dv_in) begin
          tid_d = tid_in;
          len_d = len_in;
          if (invalid) begin
            nscr_d = '1;
            tido_d = tid_in;
            st_d   = StOut;
          end else begin
            num_d = {scr_in, {FRAC{1'b0}}};
            rem_d = '0;
            cnt_d = '0;
            st_d  = StDiv;
          end
        end
      end
      StDiv: begin
        num_d = q_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NW - 1)) begin
          nscr_d = q_nx;
          tido_d = tid_q;
          st_d   = StOut;
        end
      end
      StOut:   st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= StIdle;
      num_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
      tid_q  <= '0;
      nscr_q <= '0;
      tido_q <= '0;
    end else begin
      st_q   <= st_d;
      num_q  <= num_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      tid_q  <= tid_d;
      nscr_q <= nscr_d;
      tido_q <= tido_d;
    end
  end

  logic            win, last;
  logic [NW-1:0]   best_nx;
  logic [TIDW-1:0] best_id_nx;

  // Strict less-than: ties keep the earlier id and all-ones can never win.
  always_comb begin
    win        = nscr_q < best_q;
    best_nx    = win ? nscr_q : best_q;
    best_id_nx = win ? tido_q : best_id_q;
    last       = (rcnt_q == RCW'(NTEMPL - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_q     <= '1;
      best_id_q  <= '0;
      rcnt_q     <= '0;
      best_dv_q  <= 1'b0;
      best_scr_q <= '0;
      best_ido_q <= '0;
      err_q      <= 1'b0;
    end else begin
      best_dv_q <= 1'b0;
      if (dv_in && (st_q != StIdle)) err_q <= 1'b1;
      if (st_q == StOut) begin
        if (last) begin
          best_dv_q  <= 1'b1;
          best_scr_q <= best_nx;
          best_ido_q <= best_id_nx;
          best_q     <= '1;
          best_id_q  <= '0;
          rcnt_q     <= '0;
        end else begin
          best_q    <= best_nx;
          best_id_q <= best_id_nx;
          rcnt_q    <= rcnt_q + 1'b1;
        end
      end
    end
  end

  assign busy     = (st_q != StIdle);
  assign dv_o     = (st_q == StOut);
  assign nscr_o   = nscr_q;
  assign tid_o    = tido_q;
  assign best_dv  = best_dv_q;
  assign best_id  = best_ido_q;
  assign best_scr = best_scr_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_dp_score_norm_select.sv
// Directed self-checking bench for dp_score_norm_select: latency, quotients, invalid bypass,
// round selection, dropped inputs and mid-division reset.
module tb_dp_score_norm_select;

  localparam int unsigned BIT = 32;
  localparam int unsigned FRAC = 8;
  localparam int unsigned NTEMPL = 4;
  localparam int unsigned TIDW = 4;
  localparam int unsigned SW = BIT + 13;
  localparam int unsigned NW = SW + FRAC;
  localparam logic [SW-1:0] SONES = '1;
  localparam logic [NW-1:0] NONES = '1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            dv_in = 1'b0;
  logic [SW-1:0]   scr_in = '0;
  logic [6:0]      len_in = '0;
  logic [TIDW-1:0] tid_in = '0;
  logic            busy, dv_o, best_dv, err_o;
  logic [NW-1:0]   nscr_o, best_scr;
  logic [TIDW-1:0] tid_o, best_id;

  int n_cmp = 0;
  int n_bad = 0;

  // Captured by send()
  int              lat, busy_cyc;
  logic [NW-1:0]   r_nscr;
  logic [TIDW-1:0] r_tid;
  logic            r_bdv;
  logic [TIDW-1:0] r_bid;
  logic [NW-1:0]   r_bscr;

  dp_score_norm_select #(
    .BIT(BIT), .FRAC(FRAC), .NTEMPL(NTEMPL), .TIDW(TIDW)
  ) dut (
    .clk(clk), .reset(reset), .dv_in(dv_in), .scr_in(scr_in), .len_in(len_in),
    .tid_in(tid_in), .busy(busy), .dv_o(dv_o), .nscr_o(nscr_o), .tid_o(tid_o),
    .best_dv(best_dv), .best_id(best_id), .best_scr(best_scr), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Call just after a negedge. inj>0 drives a stray dv_in that many cycles into the wait.
  task automatic send(input logic [SW-1:0] s, input logic [6:0] l, input logic [TIDW-1:0] t,
                      input int inj);
    scr_in = s; len_in = l; tid_in = t; dv_in = 1'b1;
    @(posedge clk); #1 dv_in = 1'b0;
    lat = 0; busy_cyc = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cyc++;
      if (dv_o) break;
      if (lat == inj) begin
        scr_in = 5; len_in = 1; tid_in = 9; dv_in = 1'b1;
        @(posedge clk); #1 dv_in = 1'b0;
      end
    end
    if (lat >= 200) chk("dv_o_timeout", 0, 1);
    r_nscr = nscr_o; r_tid = tid_o;
    @(negedge clk);
    r_bdv = best_dv; r_bid = best_id; r_bscr = best_scr;
  endtask

  initial begin
    #12;
    chk("rst_dv_o", dv_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_nscr", nscr_o, 0);
    chk("rst_best_scr", best_scr, 0);
    chk("rst_best_id", best_id, 0);
    chk("rst_err", err_o, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    // Round A: two divisions, two invalid bypasses
    send(1000, 10, 2, 0);
    chk("a0_lat", lat, 54);
    chk("a0_busy_cyc", busy_cyc, 54);
    chk("a0_nscr", r_nscr, 25600);
    chk("a0_tid", r_tid, 2);
    chk("a0_busy_after", busy, 0);
    send(7, 3, 1, 0);
    chk("a1_nscr", r_nscr, 597);
    send(SONES, 5, 3, 0);
    chk("a2_lat", lat, 1);
    chk("a2_nscr", r_nscr, NONES);
    chk("a2_bdv", r_bdv, 0);
    send(100, 0, 4, 0);
    chk("a3_lat", lat, 1);
    chk("a3_nscr", r_nscr, NONES);
    chk("a3_bdv", r_bdv, 1);
    chk("a3_bid", r_bid, 1);
    chk("a3_bscr", r_bscr, 597);

    // Round B: tie at 90 keeps id 2
    send(400, 4, 0, 0);
    chk("b0_bdv", r_bdv, 0);
    send(300, 2, 1, 0);
    send(90, 1, 2, 0);
    chk("b2_nscr", r_nscr, 23040);
    chk("b2_bdv", r_bdv, 0);
    send(180, 2, 3, 0);
    chk("b3_nscr", r_nscr, 23040);
    chk("b3_bdv", r_bdv, 1);
    chk("b3_bid", r_bid, 2);
    chk("b3_bscr", r_bscr, 23040);
    chk("b3_err", err_o, 0);

    // Round C: stray input mid-division is dropped and not counted
    send(200, 2, 5, 10);
    chk("c0_nscr", r_nscr, 25600);
    chk("c0_tid", r_tid, 5);
    chk("c0_lat", lat, 54);
    chk("c0_err", err_o, 1);
    send(100, 1, 6, 0);
    send(50, 1, 7, 0);
    chk("c2_bdv", r_bdv, 0);
    send(300, 1, 8, 0);
    chk("c3_nscr", r_nscr, 76800);
    chk("c3_bdv", r_bdv, 1);
    chk("c3_bid", r_bid, 7);
    chk("c3_bscr", r_bscr, 12800);
    chk("c3_err", err_o, 1);

    // Round D: all invalid
    for (int i = 0; i < 4; i++) send(SONES, 7'(i + 1), 4'(i + 3), 0);
    chk("d_bdv", r_bdv, 1);
    chk("d_bid", r_bid, 0);
    chk("d_bscr", r_bscr, NONES);

    // Reset 20 cycles into a division
    scr_in = 1000; len_in = 10; tid_in = 2; dv_in = 1'b1;
    @(posedge clk); #1 dv_in = 1'b0;
    begin
      int seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (dv_o) seen++;
      end
      reset = 1'b0;
      #1;
      chk("r_busy", busy, 0);
      chk("r_err", err_o, 0);
      chk("r_dv_o", dv_o, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (60) begin
        @(negedge clk);
        if (dv_o) seen++;
      end
      chk("r_no_dv", seen, 0);
    end
    send(7, 3, 1, 0);
    chk("r_lat", lat, 54);
    chk("r_nscr", r_nscr, 597);
    chk("r_tid", r_tid, 1);
    chk("r_bdv", r_bdv, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
